// File: rtl/best_weights_store_if.sv
// Bus bundle for best_weights_store: capture burst inputs, readout
// valid/ready stream and status outputs.
interface best_weights_store_if #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int Extra         = 2,
    parameter int Num_Unknowns  = 2
);
    localparam int IW = (Num_Unknowns > 1) ? $clog2(Num_Unknowns) : 1;

    logic                           write_en;
    logic [ELEMENT_WIDTH-1:0]       weight_in;
    logic [ELEMENT_WIDTH+Extra-1:0] best_error_in;
    logic                           train_done;
    logic [ELEMENT_WIDTH-1:0]       rd_data;
    logic [IW-1:0]                  rd_index;
    logic                           rd_valid;
    logic                           rd_ready;
    logic                           rd_last;
    logic                           rd_done;
    logic                           rd_empty;
    logic [ELEMENT_WIDTH+Extra-1:0] best_error_out;
    logic                           have_result;
    logic                           abort_pulse;

    modport master (
        output write_en, weight_in, best_error_in, train_done, rd_ready,
        input  rd_data, rd_index, rd_valid, rd_last, rd_done, rd_empty,
               best_error_out, have_result, abort_pulse
    );

    modport slave (
        input  write_en, weight_in, best_error_in, train_done, rd_ready,
        output rd_data, rd_index, rd_valid, rd_last, rd_done, rd_empty,
               best_error_out, have_result, abort_pulse
    );
endinterface

// File: rtl/best_weights_store.sv
// Ping-pong store for the best weight set. Captures Num_Unknowns-word
// bursts into the inactive bank and streams the committed bank to the
// host; a capture completing during readout is swapped in afterwards.
module best_weights_store #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int Extra         = 2,
    parameter int Num_Unknowns  = 2
) (
    input  logic                clk,
    input  logic                rst,
    best_weights_store_if.slave bus
);
    localparam int IW = (Num_Unknowns > 1) ? $clog2(Num_Unknowns) : 1;
    localparam int EW = ELEMENT_WIDTH + Extra;
    localparam logic [IW-1:0] LAST_IDX = IW'(Num_Unknowns - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t state, state_n;

    logic [ELEMENT_WIDTH-1:0] bank [2][Num_Unknowns];
    logic [EW-1:0]            errbank [2];

    logic [IW-1:0]            wcnt;
    logic                     wbank;
    logic                     commit;
    logic                     accept;
    logic                     read_end;

    logic                     rd_bank, rd_bank_n;
    logic                     swap_pending, swap_pending_n;
    logic                     have_result, have_result_n;
    logic [IW-1:0]            ridx, ridx_n;
    logic                     rd_valid_q, rd_valid_n;
    logic                     rd_done_q, rd_done_n;
    logic                     rd_empty_q, rd_empty_n;
    logic                     abort_q, abort_n;
    logic [ELEMENT_WIDTH-1:0] rd_data_q, rd_data_n;
    logic [EW-1:0]            err_q, err_n;

    assign wbank    = ~rd_bank;
    assign commit   = bus.write_en && (wcnt == LAST_IDX);
    assign accept   = (state == READ) && bus.rd_ready;
    assign read_end = accept && (ridx == LAST_IDX);

    // Capture counter: advances per write_en cycle, wraps on commit, clears on short burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (bus.write_en) begin
            wcnt <= commit ? '0 : wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    // Bank storage: captures always land in the bank not being read; no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && bus.write_en) begin
            bank[wbank][wcnt] <= bus.weight_in;
            if (wcnt == '0) begin
                errbank[wbank] <= bus.best_error_in;
            end
        end
    end

    // Readout FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Readout FSM next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.train_done && (have_result || commit)) state_n = READ;
            READ: if (read_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values for bank select, read index, pulses and the registered read/error words.
    always_comb begin
        rd_bank_n      = rd_bank;
        swap_pending_n = swap_pending;
        have_result_n  = have_result | commit;
        ridx_n         = ridx;
        rd_done_n      = 1'b0;
        rd_empty_n     = 1'b0;
        abort_n        = !bus.write_en && (wcnt != '0);
        case (state)
            IDLE: begin
                ridx_n = '0;
                if (commit) rd_bank_n = ~rd_bank;
                if (bus.train_done && !(have_result || commit)) rd_empty_n = 1'b1;
            end
            READ: begin
                if (commit) swap_pending_n = 1'b1;
                if (accept) ridx_n = ridx + 1'b1;
                if (read_end) begin
                    rd_done_n      = 1'b1;
                    ridx_n         = '0;
                    swap_pending_n = 1'b0;
                    // A commit on this very edge must also flip, otherwise it
                    // would be left pending with the FSM already idle.
                    if (swap_pending || commit) rd_bank_n = ~rd_bank;
                end
            end
            default: ;
        endcase

        rd_valid_n = (state_n == READ);

        // Forward weight_in when the word being fetched is written on this same edge.
        rd_data_n = rd_data_q;
        if (state_n == READ) begin
            if (bus.write_en && (rd_bank_n == wbank) && (wcnt == ridx_n)) begin
                rd_data_n = bus.weight_in;
            end else begin
                rd_data_n = bank[rd_bank_n][ridx_n];
            end
        end

        // The committed error only changes when the bank select flips.
        err_n = err_q;
        if (rd_bank_n != rd_bank) begin
            if (bus.write_en && (wcnt == '0)) begin
                err_n = bus.best_error_in;
            end else begin
                err_n = errbank[rd_bank_n];
            end
        end
    end

    // Registered control state and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank      <= 1'b0;
            swap_pending <= 1'b0;
            have_result  <= 1'b0;
            ridx         <= '0;
            rd_valid_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            rd_empty_q   <= 1'b0;
            abort_q      <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= '0;
        end else begin
            rd_bank      <= rd_bank_n;
            swap_pending <= swap_pending_n;
            have_result  <= have_result_n;
            ridx         <= ridx_n;
            rd_valid_q   <= rd_valid_n;
            rd_done_q    <= rd_done_n;
            rd_empty_q   <= rd_empty_n;
            abort_q      <= abort_n;
            rd_data_q    <= rd_data_n;
            err_q        <= err_n;
        end
    end

    assign bus.rd_data        = rd_data_q;
    assign bus.rd_index       = ridx;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_last        = rd_valid_q && (ridx == LAST_IDX);
    assign bus.rd_done        = rd_done_q;
    assign bus.rd_empty       = rd_empty_q;
    assign bus.best_error_out = err_q;
    assign bus.have_result    = have_result;
    assign bus.abort_pulse    = abort_q;
endmodule
